// File: rtl/seq_arith_pkg.sv
// ----------------------------------------------------------------------------
// seq_arith_pkg: shared width default and divider state type. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seq_arith_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step: one restoring-division iteration (shift, compare, subtract). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_step
   import seq_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;

   assign shifted = {rem_i, bit_i};

   // The difference always fits in WIDTH bits because it is below the divisor.
   assign qbit_o = shifted[WIDTH] | (shifted[WIDTH-1:0] >= divisor_i);
   assign rem_o  = qbit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider: unsigned 2W/W restoring divider, one quotient bit per cycle. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_divider
   import seq_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               dbz,
   output logic               ovf
);

   localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_e       state_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] divisor_q;
   logic [CNT_W-1:0] iter_q;
   logic             dbz_pend_q;
   logic             ovf_pend_q;

   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic             ovf_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;

   logic [WIDTH-1:0] rem_d;
   logic             qbit_d;
   logic             start_dbz;
   logic             start_ovf;

   assign start_dbz = (divisor == '0);
   assign start_ovf = !start_dbz && (dividend[2*WIDTH-1:WIDTH] >= divisor);

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i     (rem_q),
      .bit_i     (work_q[WIDTH-1]),
      .divisor_i (divisor_q),
      .rem_o     (rem_d),
      .qbit_o    (qbit_d)
   );

   // work_q holds the unconsumed low dividend bits and fills with quotient bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         work_q      <= '0;
         divisor_q   <= '0;
         iter_q      <= '0;
         dbz_pend_q  <= 1'b0;
         ovf_pend_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         busy_q <= (state_q == RUN);
         done_q <= (state_q == DONE);
         case (state_q)
            IDLE: begin
               if (start) begin
                  rem_q      <= dividend[2*WIDTH-1:WIDTH];
                  work_q     <= dividend[WIDTH-1:0];
                  divisor_q  <= divisor;
                  iter_q     <= '0;
                  dbz_pend_q <= start_dbz;
                  ovf_pend_q <= start_ovf;
                  state_q    <= (start_dbz || start_ovf) ? DONE : RUN;
               end
            end
            RUN: begin
               rem_q  <= rem_d;
               work_q <= {work_q[WIDTH-2:0], qbit_d};
               iter_q <= iter_q + CNT_W'(1);
               if (iter_q == LAST_ITER) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               // Error operations never shifted, so work_q still holds the low dividend half.
               quotient_q  <= (dbz_pend_q || ovf_pend_q) ? '1 : work_q;
               remainder_q <= (dbz_pend_q || ovf_pend_q) ? work_q : rem_q;
               dbz_q       <= dbz_pend_q;
               ovf_q       <= ovf_pend_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign dbz       = dbz_q;
   assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider: directed and random checks of seq_divider against a reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           dbz;
   logic           ovf;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   seq_divider #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .ovf       (ovf)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: edges left until the done pulse, plus the result it will carry.
   int         m_left       = 0;
   bit         m_normal     = 1'b0;
   logic       m_busy       = 1'b0;
   logic       m_done       = 1'b0;
   logic       m_dbz        = 1'b0;
   logic       m_ovf        = 1'b0;
   logic [W-1:0] m_q        = '0;
   logic [W-1:0] m_r        = '0;
   logic       p_dbz        = 1'b0;
   logic       p_ovf        = 1'b0;
   logic [W-1:0] p_q        = '0;
   logic [W-1:0] p_r        = '0;
   int         m_done_count = 0;

   initial begin
      bit accept;
      logic [2*W-1:0] dd;
      logic [W-1:0]   dv;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_left = 0; m_normal = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_dbz = 1'b0; m_ovf = 1'b0; m_q = '0; m_r = '0;
         end else begin
            accept = (m_left == 0) && (start == 1'b1);
            dd = dividend;
            dv = divisor;
            m_done = 1'b0;
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_done = 1'b1;
                  m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
                  m_done_count++;
               end
            end
            if (accept) begin
               p_dbz = (dv == '0);
               p_ovf = (dv != '0) && (dd[2*W-1:W] >= dv);
               if (p_dbz || p_ovf) begin
                  p_q = '1;
                  p_r = dd[W-1:0];
                  m_left = 1;
                  m_normal = 1'b0;
               end else begin
                  p_q = W'(dd / {16'h0, dv});
                  p_r = W'(dd % {16'h0, dv});
                  m_left = W + 1;
                  m_normal = 1'b1;
               end
            end
            m_busy = m_normal && (m_left >= 1) && (m_left <= W);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            check("dbz", dbz, m_dbz);
            check("ovf", ovf, m_ovf);
         end
      end
   end

   task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ed, input logic eo, input int elat);
      int lat;
      bit seen_busy;
      @(negedge clk);
      start = 1'b1; dividend = dd; divisor = dv;
      @(negedge clk);
      start = 1'b0; dividend = $urandom; divisor = W'($urandom);
      lat = 0;
      seen_busy = 1'b0;
      while (!done && lat < 60) begin
         seen_busy |= busy;
         @(negedge clk);
         lat++;
      end
      check("op_latency", lat, elat);
      check("op_quotient", quotient, eq);
      check("op_remainder", remainder, er);
      check("op_dbz", dbz, ed);
      check("op_ovf", ovf, eo);
      check("op_busy_seen", seen_busy, elat > 1);
   endtask

   task automatic gen(output logic [2*W-1:0] dd, output logic [W-1:0] dv);
      int mode;
      int d;
      int hi;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
         d = 0;
         hi = $urandom_range(0, 65535);
      end else if (mode == 1) begin
         d = $urandom_range(1, 65535);
         hi = $urandom_range(d, 65535);
      end else begin
         d = (mode == 2) ? $urandom_range(1, 15) : $urandom_range(1, 65535);
         hi = $urandom_range(0, d - 1);
      end
      dv = W'(d);
      dd = {W'(hi), W'($urandom)};
   endtask

   initial begin
      int cnt;
      int lat;
      logic [2*W-1:0] rdd;
      logic [W-1:0]   rdv;
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_quotient", quotient, 16'h0);
      check("rst_remainder", remainder, 16'h0);
      reset = 1'b0;

      run_op(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17);
      run_op(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);
      run_op(32'h00001234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1);
      run_op(32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1);

      // A second start mid-run must not disturb the first operation.
      @(negedge clk);
      start = 1'b1; dividend = 32'd1000; divisor = 16'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; dividend = 32'd5000; divisor = 16'd3;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("ignored_start_done", done, 1'b1);
      check("ignored_start_quotient", quotient, 16'd111);
      check("ignored_start_remainder", remainder, 16'd1);

      // Abort a run with reset; outputs clear and no done follows.
      @(negedge clk);
      start = 1'b1; dividend = 32'd100; divisor = 16'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_quotient", quotient, 16'h0);
      check("abort_remainder", remainder, 16'h0);
      check("abort_flags", {dbz, ovf}, 2'b00);
      cnt = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("abort_no_done", cnt, 0);
      run_op(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17);

      repeat (3000) begin
         @(negedge clk);
         reset = ($urandom_range(0, 399) == 0);
         start = ($urandom_range(0, 2) == 0);
         gen(rdd, rdv);
         dividend = rdd;
         divisor = rdv;
      end
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      repeat (30) @(negedge clk);
      check("random_ops_completed", m_done_count > 60, 1'b1);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
